// File: rtl/quad_step_gen.sv
// Quadrature front end: sync, deglitch, Gray decode, divide to ce/up steps, wrap position.
// Latency pin->ce_out is 3+FILTER_LEN cycles; no backpressure, pins are sampled every cycle.
module quad_step_gen #(
    parameter int FILTER_LEN = 4,
    parameter int DIV        = 4,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    input  logic             l,
    input  logic [WIDTH-1:0] di,
    output logic             ce_out,
    output logic             up_out,
    output logic [WIDTH-1:0] pos,
    output logic             tc,
    output logic             err
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCW-1:0] FLAST = FCW'(FILTER_LEN - 1);
    localparam int ACW = $clog2(FILTER_LEN + 3);
    localparam logic [ACW-1:0] ARM_END = ACW'(FILTER_LEN + 2);
    localparam logic signed [3:0] ACC_MAX = 4'(DIV - 1);
    localparam logic signed [3:0] ACC_MIN = -ACC_MAX;

    // Bit 1 carries channel A, bit 0 channel B, so {fa,fb} == filt.
    logic [1:0]          s1, s2, filt, prev;
    logic [1:0][FCW-1:0] fcnt;
    logic [ACW-1:0]      arm_cnt;
    logic                armed;
    logic signed [3:0]   acc;
    logic                q_up, q_dn, q_bad;
    logic                step_up, step_dn;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1   <= '0;
            s2   <= '0;
            filt <= '0;
            fcnt <= '0;
        end else begin
            s1 <= {a, b};
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FLAST) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FCW'(1);
                end
            end
        end
    end

    // armed rises one cycle after the counter ends so prev has already absorbed
    // any filtered level that settled from pins held high across reset release.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else begin
            if (arm_cnt != ARM_END)
                arm_cnt <= arm_cnt + ACW'(1);
            armed <= (arm_cnt == ARM_END);
        end
    end

    always_comb begin
        q_up  = 1'b0;
        q_dn  = 1'b0;
        q_bad = 1'b0;
        if (armed) begin
            case ({prev, filt})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: q_up  = 1'b1;
                4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: q_dn  = 1'b1;
                4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: q_bad = 1'b1;
                default: ;
            endcase
        end
    end

    assign step_up = q_up && (acc == ACC_MAX);
    assign step_dn = q_dn && (acc == ACC_MIN);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            prev   <= '0;
            acc    <= '0;
            ce_out <= 1'b0;
            up_out <= 1'b0;
            err    <= 1'b0;
            pos    <= '0;
        end else begin
            prev   <= filt;
            err    <= q_bad;
            ce_out <= step_up | step_dn;
            if (step_up | step_dn)
                up_out <= step_up;

            if (q_up)
                acc <= step_up ? 4'sd0 : acc + 4'sd1;
            else if (q_dn)
                acc <= step_dn ? 4'sd0 : acc - 4'sd1;

            if (l)
                pos <= di;
            else if (step_up)
                pos <= pos + WIDTH'(1);
            else if (step_dn)
                pos <= pos - WIDTH'(1);
        end
    end

    assign tc = up_out ? (pos == '1) : (pos == '0);

endmodule
